// File: rtl/master_out_port_param.sv
// master_out_port_param
//   Master-side serial transmit port for the system bus. It accepts one
//   parallel request (address, optional write data, mode) and handshakes it
//   to the slave with valid/ready. It then shifts address and data out
//   LSB-first on two parallel serial lines. If TIMEOUT > 0, a request the
//   slave does not take within TIMEOUT cycles is dropped and flagged.
//
// Ports
//   clk, reset    clock; asynchronous active-high reset
//   start         request strobe, taken only while master_ready is high
//   mode          1 = write (address + data), 0 = read (address only)
//   address       target address (ADDR_WIDTH bits)
//   wdata         write data (DATA_WIDTH bits)
//   slave_ready   slave can accept the request
//   master_ready  port idle
//   master_valid  request pending toward the slave
//   tx_write      latched mode while a request or transfer is in flight
//   tx_active     serial bits valid this cycle
//   tx_address    serial address bit
//   tx_data       serial data bit
//   tx_done       pulse on the final serial bit
//   timeout       pulse when a request is abandoned
module master_out_port_param #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  mode,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  slave_ready,
  output logic                  master_ready,
  output logic                  master_valid,
  output logic                  tx_write,
  output logic                  tx_active,
  output logic                  tx_address,
  output logic                  tx_data,
  output logic                  tx_done,
  output logic                  timeout
);

  localparam int unsigned SW = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int unsigned BW = $clog2(SW + 1);
  // Keep at least one bit so TIMEOUT = 0 still elaborates.
  localparam int unsigned WW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WW-1:0] WAIT_LAST = WW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {IDLE, REQ, SHIFT} state_e;

  state_e          state_q;
  logic [SW-1:0]   addr_sr_q;
  logic [SW-1:0]   data_sr_q;
  logic            mode_q;
  logic [BW-1:0]   bit_cnt_q;
  logic [WW-1:0]   wait_cnt_q;
  logic            master_ready_q, master_valid_q, tx_write_q, tx_active_q;
  logic            tx_address_q, tx_data_q, tx_done_q, timeout_q;

  logic [BW-1:0]   last_idx;
  logic [BW-1:0]   bit_cnt_inc;

  always_comb begin
    last_idx    = mode_q ? BW'(SW - 1) : BW'(ADDR_WIDTH - 1);
    bit_cnt_inc = bit_cnt_q + 1'b1;
  end

  // Shift registers are zero-extended to the longer width, and the data
  // register is cleared for reads. Bits past a field's width therefore come
  // out as 0 with no per-bit index compare.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      addr_sr_q      <= '0;
      data_sr_q      <= '0;
      mode_q         <= 1'b0;
      bit_cnt_q      <= '0;
      wait_cnt_q     <= '0;
      master_ready_q <= 1'b1;
      master_valid_q <= 1'b0;
      tx_write_q     <= 1'b0;
      tx_active_q    <= 1'b0;
      tx_address_q   <= 1'b0;
      tx_data_q      <= 1'b0;
      tx_done_q      <= 1'b0;
      timeout_q      <= 1'b0;
    end else begin
      tx_done_q <= 1'b0;
      timeout_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            addr_sr_q      <= SW'(address);
            data_sr_q      <= mode ? SW'(wdata) : '0;
            mode_q         <= mode;
            wait_cnt_q     <= '0;
            master_ready_q <= 1'b0;
            master_valid_q <= 1'b1;
            tx_write_q     <= mode;
            state_q        <= REQ;
          end
        end
        REQ: begin
          if (slave_ready) begin
            // Bit 0 goes out in the first SHIFT cycle, so it is loaded here.
            master_valid_q <= 1'b0;
            tx_active_q    <= 1'b1;
            tx_address_q   <= addr_sr_q[0];
            tx_data_q      <= data_sr_q[0];
            addr_sr_q      <= addr_sr_q >> 1;
            data_sr_q      <= data_sr_q >> 1;
            bit_cnt_q      <= '0;
            tx_done_q      <= (last_idx == '0);
            state_q        <= SHIFT;
          end else if (TIMEOUT > 0 && wait_cnt_q == WAIT_LAST) begin
            master_valid_q <= 1'b0;
            master_ready_q <= 1'b1;
            tx_write_q     <= 1'b0;
            timeout_q      <= 1'b1;
            state_q        <= IDLE;
          end else if (TIMEOUT > 0) begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
          end
        end
        SHIFT: begin
          if (bit_cnt_q == last_idx) begin
            tx_active_q    <= 1'b0;
            tx_address_q   <= 1'b0;
            tx_data_q      <= 1'b0;
            tx_write_q     <= 1'b0;
            master_ready_q <= 1'b1;
            state_q        <= IDLE;
          end else begin
            bit_cnt_q    <= bit_cnt_inc;
            tx_address_q <= addr_sr_q[0];
            tx_data_q    <= data_sr_q[0];
            addr_sr_q    <= addr_sr_q >> 1;
            data_sr_q    <= data_sr_q >> 1;
            tx_done_q    <= (bit_cnt_inc == last_idx);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign master_ready = master_ready_q;
  assign master_valid = master_valid_q;
  assign tx_write     = tx_write_q;
  assign tx_active    = tx_active_q;
  assign tx_address   = tx_address_q;
  assign tx_data      = tx_data_q;
  assign tx_done      = tx_done_q;
  assign timeout      = timeout_q;

endmodule

// File: tb/tb_master_out_port_param.sv
// tb_master_out_port_param
//   Directed bench for master_out_port_param. It runs a default instance
//   (12/8/16) and a narrow instance (ADDR_WIDTH 4, DATA_WIDTH 8). The
//   expected serial words and timings are hand-computed constants.
module tb_master_out_port_param;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        mode = 1'b0;
  logic [11:0] address = '0;
  logic [7:0]  wdata = '0;
  logic        slave_ready = 1'b0;
  logic        sel = 1'b0;
  logic        start_a, start_b;

  logic a_mr, a_mv, a_tw, a_act, a_ta, a_td, a_done, a_to;
  logic b_mr, b_mv, b_tw, b_act, b_ta, b_td, b_done, b_to;
  logic s_mr, s_mv, s_tw, s_act, s_ta, s_td, s_done, s_to;

  assign start_a = start & ~sel;
  assign start_b = start & sel;

  master_out_port_param dut_a (
    .clk(clk), .reset(reset), .start(start_a), .mode(mode),
    .address(address), .wdata(wdata), .slave_ready(slave_ready),
    .master_ready(a_mr), .master_valid(a_mv), .tx_write(a_tw),
    .tx_active(a_act), .tx_address(a_ta), .tx_data(a_td),
    .tx_done(a_done), .timeout(a_to)
  );

  master_out_port_param #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .TIMEOUT(16)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .mode(mode),
    .address(address[3:0]), .wdata(wdata), .slave_ready(slave_ready),
    .master_ready(b_mr), .master_valid(b_mv), .tx_write(b_tw),
    .tx_active(b_act), .tx_address(b_ta), .tx_data(b_td),
    .tx_done(b_done), .timeout(b_to)
  );

  assign {s_mr, s_mv, s_tw, s_act, s_ta, s_td, s_done, s_to} = sel ?
         {b_mr, b_mv, b_tw, b_act, b_ta, b_td, b_done, b_to} :
         {a_mr, a_mv, a_tw, a_act, a_ta, a_td, a_done, a_to};

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Results of the most recent capture.
  int          mv_n, nb, done_n, done_pos, to_n, to_c, tw_bad, ovl, lat;
  logic [31:0] aw, dw;

  // Issue a request; returns one step after the accepting edge.
  task automatic begin_req(input logic s, input logic m, input logic [11:0] a, input logic [7:0] d);
    sel = s; mode = m; address = a; wdata = d;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Observe the selected DUT cycle by cycle until master_ready returns.
  // lat counts edges after the accepting edge.
  task automatic capture(input int maxc, input logic exp_tw);
    mv_n = 0; nb = 0; done_n = 0; done_pos = -1; to_n = 0; to_c = -1;
    tw_bad = 0; ovl = 0; lat = -1; aw = '0; dw = '0;
    for (int c = 0; c < maxc; c++) begin
      if (s_to) begin to_n++; to_c = c; end
      if (s_done && (s_to || s_mr)) ovl++;
      if (s_mr) begin lat = c; break; end
      if (s_mv) mv_n++;
      if (s_act && nb < 32) begin
        aw[nb] = s_ta;
        dw[nb] = s_td;
        if (s_tw !== exp_tw) tw_bad++;
        if (s_done) begin done_n++; done_pos = nb; end
        nb++;
      end
      tick();
    end
    check_eq("capture_ready_within_bound", {31'b0, s_mr}, 32'd1);
  endtask

  initial begin
    // Reset state of both instances.
    repeat (3) tick();
    check_eq("reset_outs_a", {24'b0, a_mr, a_mv, a_tw, a_act, a_ta, a_td, a_done, a_to}, 32'h80);
    check_eq("reset_outs_b", {24'b0, b_mr, b_mv, b_tw, b_act, b_ta, b_td, b_done, b_to}, 32'h80);
    reset = 1'b0;
    tick();

    // Default write, slave ready throughout.
    slave_ready = 1'b1;
    begin_req(1'b0, 1'b1, 12'hA5C, 8'h3B);
    check_eq("wr_req_outs", {29'b0, a_mr, a_mv, a_tw}, 32'h3);
    capture(40, 1'b1);
    check_eq("wr_valid_cycles", mv_n, 1);
    check_eq("wr_nbits", nb, 12);
    check_eq("wr_addr_bits", aw, 32'hA5C);
    check_eq("wr_data_bits", dw, 32'h03B);
    check_eq("wr_done_count", done_n, 1);
    check_eq("wr_done_on_12th", done_pos, 11);
    check_eq("wr_tx_write", tw_bad, 0);
    // Ready in the 14th cycle counting the start cycle as the first.
    check_eq("wr_latency", lat, 13);
    check_eq("wr_no_overlap", ovl, 0);

    // Read: address only.
    begin_req(1'b0, 1'b0, 12'h001, 8'hFF);
    check_eq("rd_req_tx_write", {31'b0, a_tw}, 32'd0);
    capture(40, 1'b0);
    check_eq("rd_nbits", nb, 12);
    check_eq("rd_addr_bits", aw, 32'h001);
    check_eq("rd_data_zero", dw, 32'h0);
    check_eq("rd_tx_write", tw_bad, 0);
    check_eq("rd_done_on_12th", done_pos, 11);

    // Delayed slave_ready; inputs changed while waiting.
    slave_ready = 1'b0;
    begin_req(1'b0, 1'b1, 12'h5A3, 8'hC4);
    fork
      capture(60, 1'b1);
      begin
        address = 12'hFFF; wdata = 8'h00; mode = 1'b0;
        repeat (5) tick();
        slave_ready = 1'b1;
      end
    join
    check_eq("wait_valid_cycles", mv_n, 6);
    check_eq("wait_addr_bits", aw, 32'h5A3);
    check_eq("wait_data_bits", dw, 32'h0C4);
    check_eq("wait_tx_write", tw_bad, 0);
    check_eq("wait_latency", lat, 18);

    // Timeout: slave never ready.
    slave_ready = 1'b0;
    begin_req(1'b0, 1'b1, 12'h123, 8'h45);
    capture(60, 1'b1);
    check_eq("to_valid_cycles", mv_n, 16);
    check_eq("to_no_bits", nb, 0);
    check_eq("to_pulse_count", to_n, 1);
    check_eq("to_pulse_with_ready", to_c, 16);
    check_eq("to_no_done", done_n, 0);
    tick();
    check_eq("to_pulse_one_cycle", {31'b0, a_to}, 32'd0);

    // Reset in the middle of a write at bit 5.
    slave_ready = 1'b1;
    begin_req(1'b0, 1'b1, 12'hA5C, 8'h3B);
    repeat (6) tick();
    check_eq("rst_mid_active", {31'b0, a_act}, 32'd1);
    reset = 1'b1;
    #1;
    check_eq("rst_async_outs", {24'b0, a_mr, a_mv, a_tw, a_act, a_ta, a_td, a_done, a_to}, 32'h80);
    tick();
    check_eq("rst_held_outs", {24'b0, a_mr, a_mv, a_tw, a_act, a_ta, a_td, a_done, a_to}, 32'h80);
    reset = 1'b0;
    tick();
    begin_req(1'b0, 1'b1, 12'h3C7, 8'h5E);
    capture(40, 1'b1);
    check_eq("rst_after_nbits", nb, 12);
    check_eq("rst_after_addr", aw, 32'h3C7);
    check_eq("rst_after_data", dw, 32'h05E);

    // Narrow instance: N = 8; start pulses while busy and on tx_done.
    begin_req(1'b1, 1'b1, 12'h009, 8'hF0);
    fork
      capture(40, 1'b1);
      begin
        repeat (3) tick();
        address = 12'h006; wdata = 8'h81; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        check_eq("nb_done_cycle_not_ready", {30'b0, b_done, b_mr}, 32'h2);
        start = 1'b1;
        tick();
        start = 1'b0;
      end
    join
    check_eq("nb_nbits", nb, 8);
    check_eq("nb_addr_bits", aw, 32'h09);
    check_eq("nb_data_bits", dw, 32'hF0);
    check_eq("nb_done_on_8th", done_pos, 7);
    check_eq("nb_latency", lat, 9);
    tick();
    check_eq("nb_busy_start_ignored", {30'b0, b_mr, b_mv}, 32'h2);
    sel = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/master_out_port_param.md
Name: master_out_port_param

Overview:
Parameterised serial transmit port on the master side of the system bus. It takes one parallel request (address, optional write data, mode), performs a valid/ready handshake with the slave, and then shifts the address and data out LSB-first on two parallel serial lines. It is the successor to the fixed 12-bit address / 8-bit data master output port. New capabilities:
- generic address and data widths
- read (address-only) and write modes
- input capture at request acceptance
- a handshake timeout with an abort indication

Parameters:
ADDR_WIDTH, 12, address bits shifted on tx_address (>=1)
DATA_WIDTH, 8, data bits shifted on tx_data (>=1)
TIMEOUT, 16, max cycles in REQ waiting for slave_ready; 0 = wait forever

Ports:
clk  in  1  clock
reset  in  1  reset
start  in  1  request strobe; accepted only when master_ready=1
mode  in  1  1=write (address+data), 0=read (address only)
address  in  ADDR_WIDTH  target address
wdata  in  DATA_WIDTH  write data
slave_ready  in  1  slave can accept transfer
master_ready  out  1  port idle, can accept start
master_valid  out  1  request pending toward slave
tx_write  out  1  latched mode, valid while master_valid or tx_active
tx_active  out  1  serial bits valid this cycle
tx_address  out  1  serial address bit
tx_data  out  1  serial data bit
tx_done  out  1  one-cycle pulse on final serial bit
timeout  out  1  one-cycle pulse when request aborted

Behaviour:
Interface:
- Reset reset, asynchronous, active-high; clock clk.
- On reset: state=IDLE, counters=0, shift registers=0.
- On reset: master_ready=1; all other outputs=0.

States: IDLE, REQ, SHIFT.

IDLE:
- master_ready=1; master_valid=0; tx_* outputs=0.
- On start=1 at a clk edge: latch address, wdata and mode into internal registers; clear the wait counter; next state is REQ.
- Input changes after acceptance have no effect on the transfer.

REQ:
- master_valid=1; tx_write=latched mode; master_ready=0.
- Handshake = master_valid & slave_ready sampled at an edge. On handshake: go to SHIFT with bit counter=0.
- Otherwise the wait counter increments. If TIMEOUT>0 and the wait count reaches TIMEOUT-1 without a handshake: go to IDLE and assert timeout for exactly one cycle (the first IDLE cycle). No serial bits are sent.

SHIFT:
- master_valid=0; tx_active=1.
- Transfer length N = ADDR_WIDTH if mode=0; N = max(ADDR_WIDTH, DATA_WIDTH) if mode=1.
- Cycle k (k=0..N-1):
  - tx_address = addr[k] if k<ADDR_WIDTH, else 0.
  - tx_data = wdata[k] if mode=1 and k<DATA_WIDTH, else 0.
- tx_done=1 in cycle k=N-1 only. The next state is IDLE.
- slave_ready is ignored in SHIFT; there is no backpressure mid-transfer.

Timing:
- start sampled at edge 0. master_valid is high from edge 0.
- With slave_ready already high, the handshake occurs at edge 1 and bit 0 appears after edge 1.
- Default write: bits occupy 12 cycles, tx_done is in the 12th, and master_ready returns 1 on the following cycle. Start-to-ready latency is 14 cycles.

Boundary conditions:
- start while busy: ignored, with no queueing.
- start in the same cycle that tx_done is high: ignored; master_ready is 0 in that cycle.
- Reset mid-REQ or mid-SHIFT: immediate return to IDLE with outputs at their reset values. No tx_done and no timeout pulse.
- The bit counter is sized $clog2(max(ADDR_WIDTH,DATA_WIDTH)+1). The wait counter is sized $clog2(TIMEOUT+1).
- tx_done and timeout are never high in the same cycle.

Test Plan:
- Defaults, write addr=0xA5C, wdata=0x3B, slave_ready tied 1:
  - master_valid high 1 cycle.
  - tx_address LSB-first 0,0,1,1,1,0,1,0,0,1,0,1.
  - tx_data 1,1,0,1,1,1,0,0 then 0,0,0,0.
  - tx_done on the 12th active cycle; master_ready back after 14 cycles.
- Read addr=0x001, mode=0: tx_address 1 then eleven 0s; tx_data 0 throughout; tx_write=0; tx_done after 12 bits.
- slave_ready raised 5 cycles after master_valid:
  - master_valid held 6 cycles, then normal shift.
  - address/wdata changed during the wait do not alter the serial output.
- slave_ready held 0, TIMEOUT=16: master_valid high for 16 cycles, then timeout pulses once, master_ready=1, tx_active never 1.
- Reset asserted at bit 5 of a write: all outputs 0 and master_ready=1 asynchronously; no tx_done; next start runs a full transfer.
- ADDR_WIDTH=4, DATA_WIDTH=8, write addr=0x9, wdata=0xF0:
  - N=8; tx_address 1,0,0,1,0,0,0,0; tx_data 0,0,0,0,1,1,1,1.
  - start pulsed mid-transfer is ignored.
